// File: rtl/ps2_scancode_fifo.sv
// ps2_scancode_fifo: PS/2 frame receiver with E0/F0 folding into a FWFT event FIFO.
// Define PS2_SCANCODE_FIFO_FILTER_EN to add an 8-sample glitch filter on ps2_clk.
module ps2_scancode_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2_clk,
  input  logic                        ps2_dat,
  input  logic                        rd_en,
  input  logic                        clear_err,
  output logic [15:0]                 rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [1:0] c_q, d_q;
  logic fall, dat;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic par, tmo, stop_edge, good, frame_bad, push_req, push, pop, ovf_set;
  logic ext_pend, brk_pend;
  logic [TW-1:0] tmo_cnt;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    c_q <= reset ? 2'b11 : {c_q[0], ps2_clk};
    d_q <= reset ? 2'b11 : {d_q[0], ps2_dat};
  end
  assign dat = d_q[1];
`ifdef PS2_SCANCODE_FIFO_FILTER_EN
  // Level only follows the synchronised clock after 8 agreeing samples.
  logic [2:0] flt_cnt;
  logic flt, flt_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      flt     <= 1'b1;
      flt_d   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      flt_d   <= flt;
      flt     <= (c_q[1] != flt && flt_cnt == 3'd7) ? c_q[1] : flt;
      flt_cnt <= (c_q[1] == flt || flt_cnt == 3'd7) ? 3'd0 : flt_cnt + 3'd1;
    end
  end
  assign fall = flt_d & ~flt;
`else
  logic c_d;
  always_ff @(posedge clk) c_d <= reset ? 1'b1 : c_q[1];
  assign fall = c_d & ~c_q[1];
`endif
  assign tmo = (state != IDLE) && (tmo_cnt >= TW'(TIMEOUT_CYCLES));
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    if (tmo)
      state_nx = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_nx = dat ? IDLE : DATA;
        DATA:    state_nx = (bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_nx = STOP;
        default: state_nx = IDLE;
      endcase
  end
  always_comb begin
    stop_edge = fall && state == STOP && !tmo;
    good      = stop_edge && dat && ^{par, shreg};
    frame_bad = tmo || (fall && state == IDLE && dat) || (stop_edge && !good);
    push_req  = good && shreg != 8'hE0 && shreg != 8'hF0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= (fall || state == IDLE) ? '0 : tmo ? tmo_cnt : tmo_cnt + TW'(1);
      bit_cnt <= (state == IDLE) ? 3'd0 : (fall && state == DATA) ? bit_cnt + 3'd1 : bit_cnt;
      shreg   <= (fall && state == DATA) ? {dat, shreg[7:1]} : shreg;
      par     <= (fall && state == PARITY) ? dat : par;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      ext_pend <= (frame_bad || push_req) ? 1'b0 : (good && shreg == 8'hE0) ? 1'b1 : ext_pend;
      brk_pend <= (frame_bad || push_req) ? 1'b0 : (good && shreg == 8'hF0) ? 1'b1 : brk_pend;
    end
  end
  assign empty   = count == '0;
  assign full    = count == CW'(FIFO_DEPTH);
  assign pop     = rd_en && !empty;
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;
  assign rd_data = empty ? 16'h0000 : {1'b1, 5'b0, mem[rd_ptr]};
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {ext_pend, brk_pend, shreg};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count     <= count + CW'(push) - CW'(pop);
      overflow  <= ovf_set | (overflow & ~clear_err);
      frame_err <= frame_bad | (frame_err & ~clear_err);
    end
  end
endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// tb_ps2_scancode_fifo: directed PS/2 frames with a scoreboard-driven FIFO drain monitor.
module tb_ps2_scancode_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int H     = 20;
  logic clk = 0, reset = 1, ps2_clk = 1, ps2_dat = 1, clear_err = 0;
  logic mon_rd = 0, stim_rd = 0, drain = 0, rd_en;
  logic [15:0] rd_data;
  logic empty, full, overflow, frame_err;
  logic [3:0] count;
  int vectors = 0, errs = 0;
  logic [15:0] exp_q[$];
  assign rd_en = mon_rd | stim_rd;
  always #5 clk = ~clk;
  ps2_scancode_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rd_en(rd_en),
    .clear_err(clear_err), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .frame_err(frame_err)
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask
  task automatic send_bit(input logic b, input bit pop_on_edge);
    int n;
    ps2_dat = b;
    repeat (H) @(negedge clk);
    ps2_clk = 0;
    if (pop_on_edge) begin
      n = 0;
      while (!dut.fall && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("stop edge seen", 16'(dut.fall), 16'h1);
      stim_rd = dut.fall;
      @(negedge clk);
      stim_rd = 0;
    end
    repeat (H) @(negedge clk);
    ps2_clk = 1;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_last);
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 0);
    send_bit(~^b ^ bad_par, 0);
    send_bit(1'b1, pop_last);
    repeat (4) @(negedge clk);
  endtask
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i], 0);
  endtask
  task automatic drain_all();
    drain = 1;
    repeat (2 * DEPTH + 4) @(negedge clk);
    drain = 0;
    @(negedge clk);
    chk("drained empty", 16'(empty), 16'h1);
    chk("drained rd_data", rd_data, 16'h0000);
  endtask
  task automatic pulse_clear();
    clear_err = 1;
    @(negedge clk);
    clear_err = 0;
    @(negedge clk);
  endtask
  task automatic chk_reset_vals();
    chk("rst empty", 16'(empty), 16'h1);
    chk("rst full", 16'(full), 16'h0);
    chk("rst count", 16'(count), 16'h0);
    chk("rst rd_data", rd_data, 16'h0000);
    chk("rst overflow", 16'(overflow), 16'h0);
    chk("rst frame_err", 16'(frame_err), 16'h0);
  endtask
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      mon_rd = 0;
      if (drain && !empty && !reset) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL pop data: got %h, want nothing", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop data", rd_data, e);
        end
        mon_rd = 1;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk_reset_vals();
    send_frame(8'h29, 0, 0);
    chk("make count", 16'(count), 16'h1);
    chk("make rd_data", rd_data, 16'h8029);
    exp_q.push_back(16'h8029);
    drain_all();
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);
    chk("break count", 16'(count), 16'h1);
    exp_q.push_back(16'h8129);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("ext break count", 16'(count), 16'h2);
    exp_q.push_back(16'h8375);
    drain_all();
    send_frame(8'h1C, 1, 0);
    chk("parity frame_err", 16'(frame_err), 16'h1);
    chk("parity empty", 16'(empty), 16'h1);
    send_frame(8'h1C, 0, 0);
    chk("after parity count", 16'(count), 16'h1);
    exp_q.push_back(16'h801C);
    drain_all();
    pulse_clear();
    chk("clear frame_err", 16'(frame_err), 16'h0);
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 0, 0);
      if (i <= DEPTH) exp_q.push_back(16'h8000 | 16'(i));
    end
    chk("ovf full", 16'(full), 16'h1);
    chk("ovf flag", 16'(overflow), 16'h1);
    chk("ovf count", 16'(count), 16'h8);
    chk("ovf head", rd_data, 16'h8001);
    send_frame(8'h0A, 0, 1);
    void'(exp_q.pop_front());
    exp_q.push_back(16'h800A);
    chk("push+pop count", 16'(count), 16'h8);
    chk("push+pop full", 16'(full), 16'h1);
    chk("push+pop head", rd_data, 16'h8002);
    drain_all();
    chk("ovf sticky", 16'(overflow), 16'h1);
    pulse_clear();
    chk("ovf cleared", 16'(overflow), 16'h0);
    send_bits(11'b000_0000_1010, 5);
    chk("pre-timeout frame_err", 16'(frame_err), 16'h0);
    repeat (TMO + 20) @(negedge clk);
    chk("timeout frame_err", 16'(frame_err), 16'h1);
    chk("timeout empty", 16'(empty), 16'h1);
    pulse_clear();
    send_frame(8'h1C, 0, 0);
    chk("post-timeout count", 16'(count), 16'h1);
    chk("post-timeout frame_err", 16'(frame_err), 16'h0);
    exp_q.push_back(16'h801C);
    drain_all();
    send_frame(8'h16, 0, 0);
    chk("pre-reset count", 16'(count), 16'h1);
    send_bits(11'b000_0001_0100, 5);
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk_reset_vals();
    send_bits(11'b000_0011_0101, 6);
    repeat (TMO + 20) @(negedge clk);
    chk("residue frame_err", 16'(frame_err), 16'h1);
    chk("residue empty", 16'(empty), 16'h1);
    pulse_clear();
    send_frame(8'h29, 0, 0);
    chk("post-reset count", 16'(count), 16'h1);
    chk("post-reset frame_err", 16'(frame_err), 16'h0);
    exp_q.push_back(16'h8029);
    drain_all();
    chk("scoreboard leftover", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_fifo.md
# ps2_scancode_fifo

Receives PS/2 keyboard frames, validates them, folds E0/F0 prefix bytes into flags and buffers the resulting key events in a first-word-fall-through FIFO. It sits upstream of the CPU top level, replacing the single-key space detector with a general memory-mapped keyboard port. The CPU polls `empty` and pops events with `rd_en`.

## Interface
- `FIFO_DEPTH`, default 8: number of event entries; power of two, minimum 2.
- `TIMEOUT_CYCLES`, default 5000: `clk` cycles without a PS/2 clock falling edge before a partial frame is aborted (100 us at 50 MHz).
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock line; asynchronous.
- `ps2_dat` in 1: raw PS/2 data line; asynchronous.
- `rd_en` in 1: pop the head entry at the next rising edge; ignored when `empty`=1.
- `clear_err` in 1: clears the sticky `overflow` and `frame_err` flags.
- `rd_data` out 16: head entry, forced to 0 when empty.
  - bit 15: `!empty`.
  - bits 14:10: 0.
  - bit 9: extended (an E0 prefix preceded the code).
  - bit 8: break (an F0 prefix preceded the code).
  - bits 7:0: scan code.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `count` out $clog2(FIFO_DEPTH)+1: number of stored entries.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `frame_err` out 1: sticky; a frame failed start, parity or stop checks, or timed out.

## Operation
- **Input synchronisation.** Each of `ps2_clk` and `ps2_dat` passes through a 2-flop synchroniser. A third flop on the clock line drives falling-edge detection. All bits are sampled on a detected falling edge.
- **Receive FSM** (`IDLE`, `DATA`, `PARITY`, `STOP`):
  - `IDLE`: on an edge with dat=0 (start bit), go to `DATA` with bit count = 0. On an edge with dat=1, set `frame_err` and stay in `IDLE`.
  - `DATA`: shift in 8 bits, LSB first. After the 8th bit, go to `PARITY`.
  - `PARITY`: latch the bit, go to `STOP`.
  - `STOP`: on an edge, the frame is good if dat=1 and the 9 data+parity bits have odd parity. Otherwise set `frame_err`. Return to `IDLE` in both cases.
  - Timeout: a counter resets on every edge. If it reaches `TIMEOUT_CYCLES` in any state other than `IDLE`, return to `IDLE` and set `frame_err`.
- **Decoding** of a good byte:
  - 0xE0 sets `ext_pend`; nothing is pushed.
  - 0xF0 sets `brk_pend`; nothing is pushed.
  - Any other byte pushes {`ext_pend`, `brk_pend`, byte} and clears both pending flags.
  - A frame error also clears both pending flags.
- **FIFO:** circular buffer with read and write pointers; `count` is the occupancy.
  - Push with `full`=1 and no simultaneous pop: the event is dropped and `overflow` is set.
  - Simultaneous push and pop while full: both succeed and `count` is unchanged.
  - Simultaneous push and pop while empty: only the push occurs; the pop is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Sticky flags:** `clear_err` clears `overflow` and `frame_err`. If a set condition occurs in the same cycle as `clear_err`, the set wins.
- **Reset:** returns the FSM to `IDLE` and clears the pointers, `count`, pending flags, sticky flags and timeout counter. A frame in progress when reset asserts is discarded. Reset values:
  - `empty`=1, `full`=0, `count`=0, `rd_data`=0.
  - `overflow`=0, `frame_err`=0.

## Timing
- Synchroniser plus edge detect: a falling edge on `ps2_clk` is seen 3 `clk` cycles after the pin transition.
- Stop-bit edge detected in cycle N:
  - The FIFO write occurs at the end of cycle N.
  - `empty`, `count` and `rd_data` update in cycle N+1.
  - `frame_err` is set in cycle N+1.
- `rd_data` is valid combinationally from the head entry whenever `empty`=0. After `rd_en`, the next entry appears in the following cycle.
- Throughput: one event per PS/2 frame, about 1.1 ms at the nominal 10 kHz PS/2 clock. The FIFO is never the bottleneck for the CPU.

## Configuration
- `PS2_SCANCODE_FIFO_FILTER_EN` defined:
  - A glitch filter follows the `ps2_clk` synchroniser. The filtered level changes only after 8 consecutive identical samples.
  - Edge detection works on the filtered level, adding 8 cycles of edge latency (11 in total).
  - Pulses of 7 cycles or fewer are ignored.
- Macro undefined: no filter; edge latency is 3 cycles.
- `ps2_dat` is never filtered.

## Test plan
- Space make: frame 0x29 (parity bit 0) -> `rd_data`=0x8029, `count`=1. Pulse `rd_en` -> `rd_data`=0x0000, `empty`=1.
- Space break: frames F0, 29 -> a single entry 0x8129. Frames E0, F0, 75 -> a single entry 0x8375.
- Bad parity on 0x1C, then a good 0x1C frame:
  - After the bad frame: `frame_err`=1, `empty` stays 1.
  - After the good frame: entry 0x801C.
  - `clear_err` -> `frame_err`=0.
- Overflow at `FIFO_DEPTH`=8:
  - 9 frames 0x01..0x09 -> `full`=1, `overflow`=1, head 0x8001, the 9th event lost.
  - A push coincident with `rd_en` while full -> `count` stays 8 and the new entry is at the tail.
- Timeout: start bit plus 4 data bits, then idle for `TIMEOUT_CYCLES` -> `frame_err`=1, FSM in `IDLE`. A following frame 0x1C is received as 0x801C.
- Reset mid-frame: assert `reset` for 1 cycle after 5 bits -> all reset values restored. The rest of that frame produces `frame_err`=1 and no push; the next full frame is received correctly.
